ysyx_25010008_ctrl: RTL
=======================

Name: ysyx_25010008_ctrl

Overview:
- Multi-cycle sequencer for the single-issue core: FETCH -> DECODE -> (MEM) -> WB.
- Issues the IFU fetch request and holds the fetched instruction word stable for the decoder.
- Drives the decoder's ivalid commit qualifier, the PC write enable and the LSU request.
- Keeps an instret counter and enters a sticky halt when the core signals ebreak.

Parameters:
- WDT_CYCLES, 1024: watchdog limit in cycles for a single FETCH or MEM wait; used only with CTRL_WATCHDOG_EN.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ifu_req  out  1  fetch request; held high for the whole FETCH state.
- ifu_rvalid  in  1  fetch response valid; sampled only in FETCH.
- ifu_rdata  in  32  fetched instruction word.
- inst  out  32  latched instruction word fed to the decoder.
- ivalid  out  1  one-cycle commit pulse to the decoder; gates register, CSR and memory writes.
- pc_wen  out  1  PC update strobe; equal to ivalid.
- lsu_req  out  1  memory request; held high for the whole MEM state.
- lsu_wen  out  1  1 = store, 0 = load; valid while lsu_req is high.
- lsu_rvalid  in  1  LSU completion; sampled only in MEM.
- halt_req  in  1  ebreak indication from decode/execute; sampled only in WB.
- halted  out  1  sticky halt flag.
- instret  out  32  count of committed instructions.
- wdt_timeout  out  1  sticky watchdog flag; tied 0 when CTRL_WATCHDOG_EN is not defined.

Behaviour:
- Encoded states: FETCH, DECODE, MEM, WB, HALT.
- Reset values: state=FETCH, inst=32'h0000_0013 (NOP), instret=0, halted=0, wdt_timeout=0.
- All outputs are derived from registered state; there is no combinational path from any input to any output.
- FETCH:
  - ifu_req=1.
  - When ifu_rvalid=1 on a clock edge: inst<=ifu_rdata, next state DECODE.
  - ifu_rvalid may arrive in the first FETCH cycle, giving a 1-cycle fetch.
- DECODE:
  - One cycle for decoder and ALU operands to settle.
  - inst[6:0]==7'b0000011 (load) -> MEM with lsu_wen=0.
  - inst[6:0]==7'b0100011 (store) -> MEM with lsu_wen=1.
  - Any other opcode -> WB.
- MEM:
  - lsu_req=1 and lsu_wen stay stable until lsu_rvalid=1.
  - On lsu_rvalid=1 -> WB.
- WB:
  - ivalid=1 and pc_wen=1 for exactly this cycle.
  - instret increments by 1 at the end of this cycle, wrapping 32'hFFFF_FFFF -> 0.
  - halt_req=1 -> HALT; otherwise -> FETCH.
- HALT:
  - Absorbing state; halted=1.
  - ifu_req, lsu_req, ivalid and pc_wen all 0.
  - Only reset leaves HALT.
- Minimum cycles per instruction: 3 for non-memory instructions, 4 for loads/stores (1-cycle bus responses).
- ifu_rvalid outside FETCH and lsu_rvalid outside MEM are ignored. This covers stale responses after reset.
- Reset mid-operation: on the next edge, return to FETCH with the reset values above. ifu_req is re-asserted the cycle after reset is sampled. An in-flight LSU request is dropped.
- ivalid is never asserted in the same cycle as ifu_req or lsu_req.

Optional Feature:
- Macro: CTRL_WATCHDOG_EN.
- Defined:
  - A 32-bit wait counter clears on every state entry and increments each cycle spent in FETCH or MEM without a response.
  - When the counter reaches WDT_CYCLES-1 with no response: wdt_timeout<=1 and halted<=1, next state HALT, no commit and no instret change.
  - A response arriving on the same edge the limit is reached wins; the transfer completes normally.
- Not defined:
  - No counter is built; wdt_timeout is constant 0.
  - FETCH and MEM wait indefinitely.

Test Plan:
- Reset, then a zero-wait IFU returns 32'h00100093 (addi) -> ifu_req in cycle 1, DECODE in cycle 2, ivalid pulse in cycle 3, instret=1, ifu_req again in cycle 4.
- Load 32'h0000a103 (lw), IFU zero-wait, LSU responds after 3 cycles -> lsu_req high for 3 cycles with lsu_wen=0, then a single ivalid, instret=1.
- Store 32'h0020a023 (sw) -> lsu_wen=1 throughout MEM; ivalid is never asserted while lsu_req=1.
- Run 5 ALU instructions, then drive halt_req=1 in WB -> instret=6, halted=1, all requests 0 for 100 subsequent cycles; reset then restores instret=0 and halted=0.
- Force instret to 32'hFFFF_FFFF and commit one instruction -> instret=0. Pulse ifu_rvalid during DECODE -> ignored, inst unchanged.
- With CTRL_WATCHDOG_EN and WDT_CYCLES=8: IFU never responds -> wdt_timeout=1 and halted=1 after 8 FETCH cycles. A response on the 8th cycle -> normal commit with wdt_timeout=0. Assert reset during MEM -> FETCH on the next cycle, lsu_req=0.

Source files
------------

// File: rtl/ysyx_25010008_ctrl.sv
// ysyx_25010008_ctrl: multi-cycle FETCH -> DECODE -> (MEM) -> WB sequencer with instret and sticky halt.
// Define CTRL_WATCHDOG_EN to add a WDT_CYCLES-cycle watchdog on FETCH and MEM waits.
module ysyx_25010008_ctrl #(
  parameter int unsigned WDT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  output logic        ifu_req,
  input  logic        ifu_rvalid,
  input  logic [31:0] ifu_rdata,
  output logic [31:0] inst,
  output logic        ivalid,
  output logic        pc_wen,
  output logic        lsu_req,
  output logic        lsu_wen,
  input  logic        lsu_rvalid,
  input  logic        halt_req,
  output logic        halted,
  output logic [31:0] instret,
  output logic        wdt_timeout
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    MEM,
    WB,
    HALT
  } state_t;

  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  state_t state;

  if (WDT_CYCLES == 0) begin : g_bad_cfg
    $error("WDT_CYCLES must be non-zero");
  end

  // The PC advances exactly when an instruction commits.
  assign pc_wen = ivalid;

`ifdef CTRL_WATCHDOG_EN
  logic [31:0] wait_cnt;
  logic        wdt_hit;

  assign wdt_hit = (wait_cnt == 32'(WDT_CYCLES - 1));
`else
  assign wdt_timeout = 1'b0;
`endif

  // NOTE: every register here uses <= so all state moves together on the edge;
  // a blocking = would let later statements see half-updated values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FETCH;
      inst    <= NOP;
      ifu_req <= 1'b1;
      lsu_req <= 1'b0;
      lsu_wen <= 1'b0;
      ivalid  <= 1'b0;
      halted  <= 1'b0;
      instret <= '0;
`ifdef CTRL_WATCHDOG_EN
      wait_cnt    <= '0;
      wdt_timeout <= 1'b0;
`endif
    end else begin
      ivalid <= 1'b0;
`ifdef CTRL_WATCHDOG_EN
      // Cleared by default so any state change restarts the wait count.
      wait_cnt <= '0;
`endif
      case (state)
        FETCH: begin
          if (ifu_rvalid) begin
            inst    <= ifu_rdata;
            ifu_req <= 1'b0;
            state   <= DECODE;
          end
`ifdef CTRL_WATCHDOG_EN
          else if (wdt_hit) begin
            ifu_req     <= 1'b0;
            halted      <= 1'b1;
            wdt_timeout <= 1'b1;
            state       <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
`endif
        end
        DECODE: begin
          if (inst[6:0] == OP_LOAD || inst[6:0] == OP_STORE) begin
            lsu_req <= 1'b1;
            lsu_wen <= (inst[6:0] == OP_STORE);
            state   <= MEM;
          end else begin
            ivalid <= 1'b1;
            state  <= WB;
          end
        end
        MEM: begin
          if (lsu_rvalid) begin
            lsu_req <= 1'b0;
            ivalid  <= 1'b1;
            state   <= WB;
          end
`ifdef CTRL_WATCHDOG_EN
          else if (wdt_hit) begin
            lsu_req     <= 1'b0;
            halted      <= 1'b1;
            wdt_timeout <= 1'b1;
            state       <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
`endif
        end
        WB: begin
          instret <= instret + 32'd1;
          if (halt_req) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            ifu_req <= 1'b1;
            state   <= FETCH;
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          ifu_req <= 1'b1;
          lsu_req <= 1'b0;
          state   <= FETCH;
        end
      endcase
    end
  end

endmodule
